// File: rtl/mem_ctrl_pkg.sv
// Shared codes for the IF/MEM byte-serial memory controller: request codes,
// completion tags, FSM states and access-length normalisation.
package mem_ctrl_pkg;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  localparam logic [1:0] OWNER_IF   = 2'b00;
  localparam logic [1:0] OWNER_MEM  = 2'b01;
  localparam logic [1:0] OWNER_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Lengths 1..4 are taken as given; anything else means a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    return ((len == 3'd0) || (len > 3'd4)) ? 3'd4 : len;
  endfunction

endpackage

// File: rtl/mem_ctrl_byte_pack.sv
// Byte-lane helper: inserts a byte into a word (read assembly) and extracts
// a byte from a word (write serialisation), both at the given lane.
module mem_byte_pack
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [7:0]  byte_in,
  input  logic [1:0]  lane,
  output logic [31:0] word_ins,
  output logic [7:0]  byte_ext
);

  always_comb begin
    word_ins                       = word_in;
    word_ins[{lane, 3'b000} +: 8]  = byte_in;
    byte_ext                       = word_in[{lane, 3'b000} +: 8];
  end

endmodule

// File: rtl/mem_ctrl.sv
// Single-port byte-wide RAM controller arbitrating IF and MEM requesters;
// serialises 1..4-byte accesses and returns little-endian read data with a tag.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        if_rw_in,
  input  logic [31:0]       if_addr_in,
  input  logic [2:0]        if_len_in,
  input  logic [1:0]        mem_rw_in,
  input  logic [31:0]       mem_addr_in,
  input  logic [2:0]        mem_len_in,
  input  logic [31:0]       mem_wdata_in,
  input  logic [7:0]        ram_din_in,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic [7:0]        ram_dout_out,
  output logic              ram_wr_out,
  output logic [31:0]       data_out,
  output logic [31:0]       addr_back_out,
  output logic [1:0]        owner_out,
  output logic              busy_out,
  output logic              busy_line_out
);

  state_t            state;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rd_buf;
  logic [2:0]        len_q;
  logic [2:0]        cnt;
  logic [1:0]        own_q;

  logic [2:0]        cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              mem_req;
  logic              if_req;

  logic [31:0]       pack_word;
  logic [1:0]        pack_lane;
  logic [31:0]       pack_ins;
  logic [7:0]        pack_byte;

  assign cnt_nxt  = cnt + 3'd1;
  assign addr_nxt = addr_q[ADDR_W-1:0] + ADDR_W'(cnt_nxt);
  assign mem_req  = (mem_rw_in == RW_READ) || (mem_rw_in == RW_WRITE);
  assign if_req   = (if_rw_in == RW_READ);

  // Write presents the next byte to drive; read inserts the byte arriving now.
  always_comb begin
    pack_word = rd_buf;
    pack_lane = cnt[1:0];
    if (state == ST_WRITE) begin
      pack_word = wdata_q;
      pack_lane = cnt_nxt[1:0];
    end
  end

  mem_byte_pack u_pack (
    .word_in  (pack_word),
    .byte_in  (ram_din_in),
    .lane     (pack_lane),
    .word_ins (pack_ins),
    .byte_ext (pack_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_buf        <= '0;
      len_q         <= '0;
      cnt           <= '0;
      own_q         <= OWNER_NONE;
      ram_addr_out  <= '0;
      ram_dout_out  <= '0;
      ram_wr_out    <= 1'b0;
      data_out      <= '0;
      addr_back_out <= '0;
      owner_out     <= OWNER_NONE;
      busy_out      <= 1'b0;
      busy_line_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_req || if_req) begin
            cnt      <= '0;
            rd_buf   <= '0;
            busy_out <= 1'b1;
            if (mem_req) begin
              addr_q        <= mem_addr_in;
              len_q         <= norm_len(mem_len_in);
              wdata_q       <= mem_wdata_in;
              own_q         <= OWNER_MEM;
              busy_line_out <= 1'b0;
              ram_addr_out  <= mem_addr_in[ADDR_W-1:0];
              if (mem_rw_in == RW_WRITE) begin
                ram_dout_out <= mem_wdata_in[7:0];
                ram_wr_out   <= 1'b1;
                state        <= ST_WRITE;
              end else begin
                state <= ST_READ;
              end
            end else begin
              addr_q        <= if_addr_in;
              len_q         <= norm_len(if_len_in);
              own_q         <= OWNER_IF;
              busy_line_out <= 1'b1;
              ram_addr_out  <= if_addr_in[ADDR_W-1:0];
              state         <= ST_READ;
            end
          end
        end

        ST_READ: begin
          rd_buf <= pack_ins;
          if (cnt_nxt == len_q) begin
            data_out      <= pack_ins;
            addr_back_out <= addr_q;
            owner_out     <= own_q;
            busy_out      <= 1'b0;
            busy_line_out <= 1'b0;
            state         <= ST_DONE;
          end else begin
            cnt          <= cnt_nxt;
            ram_addr_out <= addr_nxt;
          end
        end

        ST_WRITE: begin
          if (cnt_nxt == len_q) begin
            ram_wr_out    <= 1'b0;
            addr_back_out <= addr_q;
            owner_out     <= own_q;
            busy_out      <= 1'b0;
            busy_line_out <= 1'b0;
            state         <= ST_DONE;
          end else begin
            cnt          <= cnt_nxt;
            ram_addr_out <= addr_nxt;
            ram_dout_out <= pack_byte;
          end
        end

        ST_DONE: begin
          owner_out <= OWNER_NONE;
          state     <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus predicts completions and RAM writes
// from a byte-array reference memory; negedge monitors pop and compare.
module tb_mem_ctrl;

  localparam int unsigned AW    = 17;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [31:0] AMASK = 32'h0001_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    if_rw_in = '0;
  logic [31:0]   if_addr_in = '0;
  logic [2:0]    if_len_in = '0;
  logic [1:0]    mem_rw_in = '0;
  logic [31:0]   mem_addr_in = '0;
  logic [2:0]    mem_len_in = '0;
  logic [31:0]   mem_wdata_in = '0;
  logic [7:0]    ram_din_in;
  logic [AW-1:0] ram_addr_out;
  logic [7:0]    ram_dout_out;
  logic          ram_wr_out;
  logic [31:0]   data_out;
  logic [31:0]   addr_back_out;
  logic [1:0]    owner_out;
  logic          busy_out;
  logic          busy_line_out;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_rw_in      (if_rw_in),
    .if_addr_in    (if_addr_in),
    .if_len_in     (if_len_in),
    .mem_rw_in     (mem_rw_in),
    .mem_addr_in   (mem_addr_in),
    .mem_len_in    (mem_len_in),
    .mem_wdata_in  (mem_wdata_in),
    .ram_din_in    (ram_din_in),
    .ram_addr_out  (ram_addr_out),
    .ram_dout_out  (ram_dout_out),
    .ram_wr_out    (ram_wr_out),
    .data_out      (data_out),
    .addr_back_out (addr_back_out),
    .owner_out     (owner_out),
    .busy_out      (busy_out),
    .busy_line_out (busy_line_out)
  );

  always #5 clk = ~clk;

  // Environment RAM: asynchronous read, write at the end of the cycle.
  logic [7:0] ram     [0:DEPTH-1];
  logic [7:0] ref_mem [0:DEPTH-1];
  assign ram_din_in = ram[ram_addr_out];
  always @(posedge clk) if (ram_wr_out) ram[ram_addr_out] <= ram_dout_out;

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] addr;
    logic [31:0] data;
  } comp_t;

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
  } wr_t;

  comp_t       cq[$];
  wr_t         wq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        mon_en = 1'b0;
  logic [31:0] last_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  comp_t mon_c;
  wr_t   mon_w;
  always @(negedge clk) begin
    if (mon_en) begin
      if (owner_out != 2'b11) begin
        checks++;
        if (cq.size() == 0) begin
          errors++;
          $display("FAIL completion_unexpected got owner=%b addr=%h data=%h", owner_out, addr_back_out, data_out);
        end else begin
          mon_c = cq.pop_front();
          if (owner_out !== mon_c.owner || addr_back_out !== mon_c.addr ||
              data_out !== mon_c.data || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL completion got owner=%b addr=%h data=%h busy=%b want owner=%b addr=%h data=%h busy=0",
                     owner_out, addr_back_out, data_out, busy_out, mon_c.owner, mon_c.addr, mon_c.data);
          end
        end
      end
      if (ram_wr_out) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL ram_write_unexpected got addr=%h byte=%h", ram_addr_out, ram_dout_out);
        end else begin
          mon_w = wq.pop_front();
          if (ram_addr_out !== mon_w.addr || ram_dout_out !== mon_w.data) begin
            errors++;
            $display("FAIL ram_write got addr=%h byte=%h want addr=%h byte=%h",
                     ram_addr_out, ram_dout_out, mon_w.addr, mon_w.data);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: len 0/>4 is a word; byte k lives at (addr+k) mod 2**AW.
  task automatic predict(input logic is_mem, input logic wr, input logic [31:0] a,
                         input logic [2:0] len, input logic [31:0] wd);
    int unsigned n;
    logic [16:0] ra;
    logic [31:0] d;
    comp_t       e;
    wr_t         w;
    n = (len == 3'd0 || len > 3'd4) ? 4 : int'(len);
    d = '0;
    for (int unsigned k = 0; k < n; k++) begin
      ra = 17'((a + k) & AMASK);
      if (wr) begin
        w.addr = ra;
        w.data = wd[8*k +: 8];
        wq.push_back(w);
        ref_mem[ra] = w.data;
      end else begin
        d = d | (32'(ref_mem[ra]) << (8 * k));
      end
    end
    if (wr) d = last_rd;
    else last_rd = d;
    e.owner = is_mem ? 2'b01 : 2'b00;
    e.addr  = a;
    e.data  = d;
    cq.push_back(e);
  endtask

  task automatic wait_accept(input logic want_line, output int t);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (busy_out) ok = 1'b1;
    end
    t = cyc;
    checks++;
    if (!ok || busy_line_out !== want_line) begin
      errors++;
      $display("FAIL accept got busy=%b busy_line=%b want busy=1 busy_line=%b", busy_out, busy_line_out, want_line);
    end
  endtask

  task automatic wait_owner(input logic [1:0] tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (owner_out == tag) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL owner_timeout got=%b want=%b", owner_out, tag);
    end
  endtask

  task automatic mem_txn(input logic wr, input logic [31:0] a, input logic [2:0] len, input logic [31:0] wd);
    int t;
    predict(1'b1, wr, a, len, wd);
    mem_rw_in    = wr ? 2'b10 : 2'b01;
    mem_addr_in  = a;
    mem_len_in   = len;
    mem_wdata_in = wd;
    wait_accept(1'b0, t);
    wait_owner(2'b01);
    mem_rw_in = 2'b00;
  endtask

  task automatic if_txn(input logic [31:0] a, input logic [2:0] len);
    int t;
    predict(1'b0, 1'b0, a, len, '0);
    if_rw_in   = 2'b01;
    if_addr_in = a;
    if_len_in  = len;
    wait_accept(1'b1, t);
    wait_owner(2'b00);
    if_rw_in = 2'b00;
  endtask

  logic [31:0] pool [4];

  initial begin
    int          t1;
    int          t2;
    logic [7:0]  v;
    logic [31:0] a;
    logic [31:0] wd;
    int unsigned r;

    for (int i = 0; i < int'(DEPTH); i++) begin
      v = 8'($urandom);
      ram[i]     = v;
      ref_mem[i] = v;
    end
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    ref_mem[32'h100] = 8'h13; ref_mem[32'h101] = 8'h05; ref_mem[32'h102] = 8'h00; ref_mem[32'h103] = 8'h00;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_owner", 32'(owner_out), 32'h3);
    chk("rst_busy", 32'(busy_out), 32'h0);
    chk("rst_busy_line", 32'(busy_line_out), 32'h0);
    chk("rst_ram_wr", 32'(ram_wr_out), 32'h0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_addr_back", addr_back_out, 32'h0);
    chk("rst_ram_addr", 32'(ram_addr_out), 32'h0);
    rst    = 1'b0;
    mon_en = 1'b1;
    tick();

    if_txn(32'h0000_0100, 3'd4);
    chk("if_read_0x100", data_out, 32'h0000_0513);

    mem_txn(1'b1, 32'h0001_FFFF, 3'd2, 32'h0000_BEEF);
    chk("wrap_write_hi", 32'(ram[17'h1FFFF]), 32'hEF);
    chk("wrap_write_lo", 32'(ram[17'h00000]), 32'hBE);

    // Simultaneous requests: MEM wins, IF waits for the next IDLE.
    predict(1'b1, 1'b0, 32'h0000_0101, 3'd1, '0);
    predict(1'b0, 1'b0, 32'h0000_0200, 3'd4, '0);
    mem_rw_in   = 2'b01; mem_addr_in = 32'h0000_0101; mem_len_in = 3'd1;
    if_rw_in    = 2'b01; if_addr_in  = 32'h0000_0200; if_len_in  = 3'd4;
    wait_accept(1'b0, t1);
    wait_owner(2'b01);
    chk("mem_len1_zero_ext", data_out, 32'h0000_0005);
    mem_rw_in = 2'b00;
    wait_accept(1'b1, t1);
    wait_owner(2'b00);
    if_rw_in = 2'b00;

    // Reset while the second byte of a word write is on the bus.
    for (int k = 0; k < 2; k++) begin
      wr_t w;
      w.addr = 17'(32'h0000_0400 + k);
      w.data = 8'(32'hA1B2_C3D4 >> (8 * k));
      wq.push_back(w);
      ref_mem[w.addr] = w.data;
    end
    mem_rw_in = 2'b10; mem_addr_in = 32'h0000_0400; mem_len_in = 3'd4; mem_wdata_in = 32'hA1B2_C3D4;
    wait_accept(1'b0, t1);
    tick();
    chk("abort_byte1_addr", 32'(ram_addr_out), 32'h401);
    chk("abort_byte1_wr", 32'(ram_wr_out), 32'h1);
    rst       = 1'b1;
    mem_rw_in = 2'b00;
    tick();
    chk("abort_ram_wr", 32'(ram_wr_out), 32'h0);
    chk("abort_owner", 32'(owner_out), 32'h3);
    chk("abort_busy", 32'(busy_out), 32'h0);
    chk("abort_busy_line", 32'(busy_line_out), 32'h0);
    rst = 1'b0;
    tick();
    tick();
    if_txn(32'h0000_0400, 3'd4);

    mem_txn(1'b0, 32'h0000_0100, 3'd0, '0);
    mem_txn(1'b1, 32'h0000_0500, 3'd7, 32'h1122_3344);
    mem_txn(1'b0, 32'h0000_0500, 3'd7, '0);

    // Held IF request: consecutive accepts 6 cycles apart.
    predict(1'b0, 1'b0, 32'h0000_0100, 3'd4, '0);
    predict(1'b0, 1'b0, 32'h0000_0100, 3'd4, '0);
    if_rw_in = 2'b01; if_addr_in = 32'h0000_0100; if_len_in = 3'd4;
    wait_accept(1'b1, t1);
    wait_owner(2'b00);
    wait_accept(1'b1, t2);
    chk("throughput_spacing", 32'(t2 - t1), 32'd6);
    wait_owner(2'b00);
    if_rw_in = 2'b00;

    pool[0] = 32'h0000_0100;
    pool[1] = 32'h0001_FFFE;
    pool[2] = 32'hFFFF_FFFD;
    pool[3] = 32'h0000_0600;
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 2);
      a  = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 3)];
      wd = $urandom;
      if (r == 0) if_txn(a, 3'($urandom_range(0, 7)));
      else        mem_txn(r == 2, a, 3'($urandom_range(0, 7)), wd);
    end

    for (int i = 0; i < 5; i++) tick();
    chk("completions_drained", 32'(cq.size()), 32'd0);
    chk("writes_drained", 32'(wq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
